// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared definitions for the snoop bus arbiter and the L1 requesters that drive it.
package snoop_bus_arbiter_pkg;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Cycle counts the requesters place on bus_req_clc.
  localparam int unsigned CYCLE_NUM_ADDR = 2;
  localparam int unsigned CYCLE_NUM_DATA = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/snoop_bus_arbiter_rr_priority_pick.sv
// Circular first-set picker: the first request at or after rr_ptr, wrapping upward.
module rr_priority_pick
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_CORE = 2,
  parameter int unsigned ID_W   = 3
) (
  input  logic [N_CORE-1:0] req,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic [N_CORE-1:0] winner,
  output logic [ID_W-1:0]   winner_idx,
  output logic              valid
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Lowest request at/above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (req[i] && !hi_found && (i >= 32'(rr_ptr))) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
    valid      = lo_found;
    winner_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      winner[i] = valid && (winner_idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter with write-back priority and snoop broadcast.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_CORE      = 2,
  parameter int unsigned CLC_W       = 4,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned WB_PRIORITY = 1
) (
  input  logic                    plusclk,
  input  logic                    rst,
  input  logic [N_CORE-1:0]       bus_req,
  input  logic [N_CORE-1:0]       bus_req_op,
  input  logic [N_CORE*CLC_W-1:0] bus_req_clc,
  output logic [N_CORE-1:0]       bus_get,
  output logic                    bus_busy,
  output logic [ID_W-1:0]         bus_owner,
  output logic                    bus_op,
  output logic [N_CORE-1:0]       snp_valid,
  output logic                    grant_last
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              op_q, op_d;
  logic [CLC_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;

  logic [N_CORE-1:0] owner_oh;
  logic              owner_req;
  logic              grant_end;
  logic [ID_W-1:0]   owner_inc;
  logic [N_CORE-1:0] arb_req;
  logic [N_CORE-1:0] wr_req;
  logic [N_CORE-1:0] cand;
  logic [ID_W-1:0]   arb_ptr;
  logic [N_CORE-1:0] pick_oh;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_valid;
  logic [CLC_W-1:0]  win_clc;
  logic              win_op;

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      owner_oh[i] = (state_q == GRANT) && (owner_q == ID_W'(i));
    end
  end

  assign owner_req = |(bus_req & owner_oh);
  assign grant_end = (state_q == GRANT) && ((rem_q == CLC_W'(1)) || !owner_req);
  assign owner_inc = (owner_q == ID_W'(N_CORE - 1)) ? '0 : owner_q + ID_W'(1);

  // At the end of a grant the owner is excluded and the search starts just past it,
  // so the hand-off arbitration happens on the same edge the grant ends.
  assign arb_req = (state_q == GRANT) ? (bus_req & ~owner_oh) : bus_req;
  assign arb_ptr = (state_q == GRANT) ? owner_inc : rr_ptr_q;

  always_comb begin
    wr_req = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      wr_req[i] = arb_req[i] && (bus_req_op[i] == WR);
    end
    cand = ((WB_PRIORITY != 0) && (|wr_req)) ? wr_req : arb_req;
  end

  rr_priority_pick #(
    .N_CORE (N_CORE),
    .ID_W   (ID_W)
  ) u_pick (
    .req        (cand),
    .rr_ptr     (arb_ptr),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    win_clc = '0;
    win_op  = RD;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      if (pick_oh[i]) begin
        win_clc = bus_req_clc[i*CLC_W +: CLC_W];
        win_op  = bus_req_op[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    rem_d    = rem_q;
    first_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          op_d    = win_op;
          rem_d   = (win_clc == '0) ? CLC_W'(1) : win_clc;
          first_d = 1'b1;
        end
      end
      GRANT: begin
        if (grant_end) begin
          rr_ptr_d = owner_inc;
          if (pick_valid) begin
            owner_d = pick_idx;
            op_d    = win_op;
            rem_d   = (win_clc == '0) ? CLC_W'(1) : win_clc;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            op_d    = RD;
            rem_d   = '0;
          end
        end else begin
          rem_d = rem_q - CLC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge plusclk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      op_q     <= RD;
      rem_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
    end
  end

  assign bus_get    = owner_oh;
  assign bus_busy   = (state_q == GRANT);
  assign bus_owner  = owner_q;
  assign bus_op     = op_q;
  assign snp_valid  = first_q ? ~owner_oh : '0;
  assign grant_last = (state_q == GRANT) && (rem_q == CLC_W'(1));

endmodule
